// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_pkg : shared types, defaults and helpers for regfile_param   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1
    } state_t;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_clr_fsm : sequential clear engine, zeroes registers 1..N-1   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEF,
    localparam int AW   = idx_w(NREG)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_done_o,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_idx_o
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_last;

    assign w_last = (r_cnt == AW'(NREG - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= CLEAR;
            r_cnt   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (clr_req_i) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                w_cnt_nxt = r_cnt + AW'(1);
                if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            // Unused encoding: restart a full clear rather than trust the array.
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = AW'(1);
            end
        endcase
    end

    assign busy_o     = (r_state != IDLE);
    assign clr_we_o   = (r_state == CLEAR);
    assign clr_idx_o  = r_cnt;
    assign clr_done_o = clr_we_o & w_last;

endmodule
`default_nettype wire

// File: rtl/regfile_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_param : parametrised register file, x0 = 0, optional bypass  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREG   = NREG_DEF,
    parameter  int NRP    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = idx_w(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wren_i,
    input  logic [AW-1:0]       rd_i,
    input  logic [XLEN-1:0]     datard_i,
    input  logic [NRP*AW-1:0]   rs_i,
    output logic [NRP*XLEN-1:0] datars_o,
    input  logic                clr_req_i,
    output logic                busy_o,
    output logic                clr_done_o
);

    logic [XLEN-1:0] r_mem [NREG];

    logic            w_busy;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_idx;
    logic            w_user_we;
    logic            w_we;
    logic [AW-1:0]   w_wr_idx;
    logic [XLEN-1:0] w_wr_data;

    regfile_clr_fsm #(
        .NREG (NREG)
    ) u_clr_fsm (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_req_i  (clr_req_i),
        .busy_o     (w_busy),
        .clr_done_o (clr_done_o),
        .clr_we_o   (w_clr_we),
        .clr_idx_o  (w_clr_idx)
    );

    // A clear request in IDLE takes the cycle, so a simultaneous write is dropped.
    assign w_user_we = !w_busy && wren_i && !clr_req_i && (rd_i != '0);
    assign w_we      = w_clr_we | w_user_we;
    assign w_wr_idx  = w_clr_we ? w_clr_idx : rd_i;
    assign w_wr_data = w_clr_we ? '0 : datard_i;
    assign busy_o    = w_busy;

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_wr_idx] <= w_wr_data;
        end
    end

    for (genvar p = 0; p < NRP; p++) begin : g_rd
        logic [AW-1:0]   w_rs;
        logic [XLEN-1:0] w_rdata;

        assign w_rs = rs_i[p*AW +: AW];

        always_comb begin
            w_rdata = '0;
            if (w_busy || (w_rs == '0)) begin
                w_rdata = '0;
            end else if ((BYPASS != 0) && w_user_we && (rd_i == w_rs)) begin
                w_rdata = datard_i;
            end else begin
                w_rdata = r_mem[w_rs];
            end
        end

        assign datars_o[p*XLEN +: XLEN] = w_rdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_param : directed self-checking bench for regfile_param    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    // Shared stimulus for the default (bypass) and no-bypass instances.
    logic        wren;
    logic [4:0]  rd;
    logic [31:0] datard;
    logic [9:0]  rs;
    logic        clr_req;
    logic [63:0] rdat_a, rdat_b;
    logic        busy_a, done_a, busy_b, done_b;
    // Small instance: NREG=8, XLEN=16, NRP=3.
    logic        wren_c;
    logic [2:0]  rd_c;
    logic [15:0] datard_c;
    logic [8:0]  rs_c;
    logic        clr_req_c;
    logic [47:0] rdat_c;
    logic        busy_c, done_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_param #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .wren_i(wren), .rd_i(rd), .datard_i(datard),
        .rs_i(rs), .datars_o(rdat_a), .clr_req_i(clr_req), .busy_o(busy_a), .clr_done_o(done_a)
    );

    regfile_param #(.XLEN(32), .NREG(32), .NRP(2), .BYPASS(0)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .wren_i(wren), .rd_i(rd), .datard_i(datard),
        .rs_i(rs), .datars_o(rdat_b), .clr_req_i(clr_req), .busy_o(busy_b), .clr_done_o(done_b)
    );

    regfile_param #(.XLEN(16), .NREG(8), .NRP(3), .BYPASS(1)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_n), .wren_i(wren_c), .rd_i(rd_c), .datard_i(datard_c),
        .rs_i(rs_c), .datars_o(rdat_c), .clr_req_i(clr_req_c), .busy_o(busy_c), .clr_done_o(done_c)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Counts busy cycles and the cycle of the done pulse for A and C; optionally
    // pulses clr_req during the clear to show it is ignored there.
    task automatic count_clear(input int req_at, output int ac, output int ad,
                               output int cc, output int cd);
        ac = 0; ad = 0; cc = 0; cd = 0;
        for (int k = 1; k <= 100 && (busy_a || busy_c); k++) begin
            if (busy_a) ac++;
            if (done_a) ad = ac;
            if (busy_c) cc++;
            if (done_c) cd = cc;
            clr_req = (k == req_at);
            tick();
        end
        clr_req = 1'b0;
    endtask

    task automatic read_all(output logic [63:0] acc);
        acc = '0;
        for (int i = 0; i < 32; i++) begin
            rs = {5'(i), 5'(31 - i)};
            #1;
            acc = acc | rdat_a | rdat_b;
        end
    endtask

    initial begin
        int          ac, ad, cc, cd;
        logic [63:0] acc;

        rst_n = 1'b0; wren = 1'b0; rd = '0; datard = '0; rs = '0; clr_req = 1'b0;
        wren_c = 1'b0; rd_c = '0; datard_c = '0; rs_c = '0; clr_req_c = 1'b0;

        // Reset held for three cycles
        repeat (3) tick();
        rs = {5'd5, 5'd3}; rs_c = {3'd1, 3'd2, 3'd3};
        #1;
        chk("rst_busy_a", 96'(busy_a), 96'd1);
        chk("rst_done_a", 96'(done_a), 96'd0);
        chk("rst_rdat_a", 96'(rdat_a), 96'd0);
        chk("rst_busy_c", 96'(busy_c), 96'd1);
        chk("rst_rdat_c", 96'(rdat_c), 96'd0);

        rst_n = 1'b1;
        #1;
        count_clear(0, ac, ad, cc, cd);
        chk("init_clr_cycles_a", 96'(ac), 96'd31);
        chk("init_clr_done_a",   96'(ad), 96'd31);
        chk("init_clr_cycles_c", 96'(cc), 96'd7);
        chk("init_clr_done_c",   96'(cd), 96'd7);
        chk("init_idle_busy_b",  96'(busy_b), 96'd0);
        read_all(acc);
        chk("init_reads_zero", 96'(acc), 96'd0);

        // Write r5, read on both ports the next cycle
        rs = '0; wren = 1'b1; rd = 5'd5; datard = 32'hDEADBEEF;
        tick();
        wren = 1'b0; rs = {5'd5, 5'd5};
        #1;
        chk("wr_r5_a", 96'(rdat_a), 96'({32'hDEADBEEF, 32'hDEADBEEF}));
        chk("wr_r5_b", 96'(rdat_b), 96'({32'hDEADBEEF, 32'hDEADBEEF}));

        // Register 0 is never written
        rs = '0; wren = 1'b1; rd = 5'd0; datard = 32'h12345678;
        #1;
        chk("r0_same_cycle_a", 96'(rdat_a), 96'd0);
        tick();
        wren = 1'b0; rs = {5'd5, 5'd0};
        #1;
        chk("r0_after_a", 96'(rdat_a), 96'({32'hDEADBEEF, 32'h0}));
        chk("r0_after_b", 96'(rdat_b), 96'({32'hDEADBEEF, 32'h0}));

        // Bypass versus no bypass on r7
        wren = 1'b1; rd = 5'd7; datard = 32'h11111111;
        tick();
        rd = 5'd7; datard = 32'hA5A5A5A5; rs = {5'd5, 5'd7};
        #1;
        chk("bypass_a", 96'(rdat_a), 96'({32'hDEADBEEF, 32'hA5A5A5A5}));
        chk("nobypass_b", 96'(rdat_b), 96'({32'hDEADBEEF, 32'h11111111}));
        tick();
        wren = 1'b0;
        #1;
        chk("r7_after_b", 96'(rdat_b[31:0]), 96'h0A5A5A5A5);

        // Small instance: three independent ports
        wren_c = 1'b1; rd_c = 3'd1; datard_c = 16'h1111;
        tick();
        rd_c = 3'd2; datard_c = 16'h2222;
        tick();
        rd_c = 3'd6; datard_c = 16'h6666;
        tick();
        wren_c = 1'b0; rs_c = {3'd6, 3'd2, 3'd1};
        #1;
        chk("c_three_ports", 96'(rdat_c), 96'({16'h6666, 16'h2222, 16'h1111}));
        rs_c = {3'd2, 3'd0, 3'd2};
        #1;
        chk("c_same_reg", 96'(rdat_c), 96'({16'h2222, 16'h0, 16'h2222}));
        clr_req_c = 1'b1; wren_c = 1'b1; rd_c = 3'd1; datard_c = 16'hFFFF;
        tick();
        clr_req_c = 1'b0; wren_c = 1'b0;
        count_clear(0, ac, ad, cc, cd);
        chk("c_req_clr_cycles", 96'(cc), 96'd7);
        rs_c = {3'd6, 3'd2, 3'd1};
        #1;
        chk("c_after_clr", 96'(rdat_c), 96'd0);

        // Fill r1..r31, then clear request colliding with a write
        for (int i = 1; i < 32; i++) begin
            wren = 1'b1; rd = 5'(i); datard = 32'(i);
            tick();
        end
        wren = 1'b0; rs = {5'd31, 5'd3};
        #1;
        chk("fill_readback", 96'(rdat_a), 96'({32'd31, 32'd3}));
        wren = 1'b1; rd = 5'd3; datard = 32'hFF; clr_req = 1'b1;
        #1;
        chk("clr_beats_bypass", 96'(rdat_a[31:0]), 96'd3);
        tick();
        wren = 1'b0; clr_req = 1'b0;
        count_clear(5, ac, ad, cc, cd);
        chk("req_clr_cycles_a", 96'(ac), 96'd31);
        chk("req_clr_done_a",   96'(ad), 96'd31);
        read_all(acc);
        chk("req_reads_zero", 96'(acc), 96'd0);

        // Reset in the middle of a clear
        wren = 1'b1; rd = 5'd5; datard = 32'hCAFEF00D;
        tick();
        wren = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0; rs = {5'd5, 5'd5};
        #1;
        chk("busy_read_zero", 96'(rdat_a), 96'd0);
        repeat (9) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        chk("midrst_busy_a", 96'(busy_a), 96'd1);
        chk("midrst_done_a", 96'(done_a), 96'd0);
        rst_n = 1'b1;
        #1;
        count_clear(0, ac, ad, cc, cd);
        chk("midrst_cycles_a", 96'(ac), 96'd31);
        chk("midrst_done_at_a", 96'(ad), 96'd31);
        chk("midrst_cycles_c", 96'(cc), 96'd7);
        read_all(acc);
        chk("midrst_reads_zero", 96'(acc), 96'd0);

        // First write right after a clear completes
        wren = 1'b1; rd = 5'd9; datard = 32'h0BADF00D;
        tick();
        wren = 1'b0; rs = {5'd9, 5'd0};
        #1;
        chk("post_clr_write", 96'(rdat_b), 96'({32'h0BADF00D, 32'h0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
# regfile_param

Parametrised integer register file for the single-cycle core, replacing the fixed 32×32 file. It has a configurable register count, data width and number of asynchronous read ports. Register 0 is hard-wired to zero, and a write-to-read bypass is optional. A sequential clear engine zeroes the whole array after reset or on request. It sits between decode (rs/rd fields) and the ALU operand and write-back paths.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of registers, power of two, ≥4
- NRP, 2, number of read ports, ≥1
- BYPASS, 1, 1 = read port returns datard_i when the same register is written in the same cycle
- AW (localparam), $clog2(NREG), register index width

- clk_i  in  1  clock, all state updates on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- wren_i  in  1  write enable
- rd_i  in  AW  write register index
- datard_i  in  XLEN  write data
- rs_i  in  NRP*AW  read indices, port p at bits [p*AW +: AW]
- datars_o  out  NRP*XLEN  read data, port p at bits [p*XLEN +: XLEN]
- clr_req_i  in  1  request a full clear, sampled in IDLE only
- busy_o  out  1  clear in progress
- clr_done_o  out  1  one-cycle pulse on the last clear write

## Operation
- FSM states: IDLE and CLEAR. A 2-bit state encoding is sufficient.
- Reset asserted: state goes to CLEAR, clear counter goes to 1, clr_done_o goes to 0.
  - busy_o is 1 while reset is asserted and until the clear completes.
  - Array contents are not reset directly; the clear engine zeroes them.
- CLEAR: each cycle writes 0 to register[counter], then the counter increments.
  - When the counter equals NREG-1, that register is written, clr_done_o pulses for that cycle, and the next state is IDLE.
- IDLE with clr_req_i=1: next state is CLEAR, counter goes to 1, and no user write happens that cycle.
  - clr_req_i is ignored in CLEAR.
- User write: happens on the edge when state=IDLE, wren_i=1, clr_req_i=0 and rd_i≠0.
  - Writes to register 0 are discarded.
  - Writes while busy are discarded. Callers must hold them off using busy_o.
- Read port p is combinational and evaluated in priority order:
  - if busy_o=1, output 0;
  - else if rs=0, output 0;
  - else if BYPASS=1 and a user write is occurring this cycle with rd_i=rs, output datard_i;
  - else output register[rs].
- Multiple read ports addressing the same register return identical data.
- Register 0 is never stored. Its entry may be optimised away.

## Timing
- Read latency is 0 cycles (asynchronous). Write latency is 1 edge: the value is visible on the next cycle without bypass, or in the same cycle with BYPASS=1.
- A clear takes exactly NREG-1 cycles from the first CLEAR edge.
  - busy_o falls in the cycle after the clr_done_o pulse.
  - The first user write is accepted in that cycle.
- Reset deasserted mid-clear: the clear restarts from register 1. A second reset restarts it again.
- clr_req_i and wren_i high together in IDLE: the clear wins and the write is dropped.
- Reset values: busy_o=1, clr_done_o=0, datars_o=0.

## Structure
- Shared package regfile_pkg: state enum {IDLE, CLEAR}, default XLEN/NREG constants, and a function idx_w(n) = $clog2(n).
- Sub-module regfile_clr_fsm: state register, counter, busy_o and clr_done_o.
  - It outputs clr_we (clear write enable) and clr_idx (clear write index) to the array write mux.
- The top level contains the array, the write mux (clear vs user) and a generate loop over the NRP read ports.

## Test plan
- Reset then idle:
  - hold rst_ni=0 for 3 cycles, then release;
  - expect busy_o=1 for 31 cycles, clr_done_o pulsing on the 31st, then busy_o=0;
  - expect every rs read to return 0.
- Write/read: write 0xDEADBEEF to r5, read r5 on port 0 and port 1 → both 0xDEADBEEF the next cycle.
- Register 0: write 0x12345678 to r0 → rs=0 returns 0 on all ports, same cycle and after.
- Bypass with BYPASS=1: wren_i=1, rd_i=7, datard_i=0xA5A5A5A5, rs_i port0=7 → port0=0xA5A5A5A5 in the same cycle. With BYPASS=0, port0 keeps the old r7 value.
- Clear request:
  - fill r1..r31 with index values, pulse clr_req_i together with wren_i (rd=3, data=0xFF);
  - expect busy_o=1 for 31 cycles, then all reads 0, and r3≠0xFF.
- Reset mid-clear: assert rst_ni=0 at clear cycle 10, release → the clear restarts and takes a full 31 cycles. Also run with NREG=8, XLEN=16, NRP=3 → clear takes 7 cycles and all three ports operate independently.
